// File: rtl/conversionFunctions.sv
// Shared Gray/binary conversion helpers used by the pointer logic of the FIFO.
package conversionFunctions;

    localparam int CONV_FIFO_DEPTH = 512;
    localparam int CONV_PNTR_WIDTH = $clog2(CONV_FIFO_DEPTH);

    // Pointers carry one extra wrap bit above the address bits.
    typedef logic [CONV_PNTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[CONV_PNTR_WIDTH] = g[CONV_PNTR_WIDTH];
        for (int i = CONV_PNTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer, cleared by the async active-low reset.
module ptr_sync #(
    parameter int WIDTH = 10
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo_core.sv
// Gray-pointer FIFO on a single clock with dual-clock-style 2-flop pointer synchronizers.
// Define ASYNC_FIFO_BYPASS_SYNC_EN to remove the sync flops and compare live Gray pointers.
module async_fifo_core
    import conversionFunctions::*;
#(
    parameter int DATA_LEN   = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int PNTR_WIDTH = $clog2(FIFO_DEPTH)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                write_en,
    input  logic                read_en,
    input  logic [DATA_LEN-1:0] data_in,
    output logic [DATA_LEN-1:0] data_out,
    output logic                fifo_full,
    output logic                fifo_empty
);

    localparam logic [PNTR_WIDTH:0] PTR_ONE     = {{PNTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PNTR_WIDTH:0] DEPTH_LEVEL = {1'b1, {PNTR_WIDTH{1'b0}}};

    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];

    logic [PNTR_WIDTH:0] wptr_bin,  wptr_gray, wptr_next;
    logic [PNTR_WIDTH:0] rptr_bin,  rptr_gray, rptr_next;
    logic [PNTR_WIDTH:0] wptr_gray_sync, rptr_gray_sync;
    logic [PNTR_WIDTH:0] write_pointer_bin_rdclk, read_pointer_bin_wrclk;
    logic [PNTR_WIDTH:0] wr_side_level, rd_side_level;
    logic                write_ok, read_ok;

    assign write_ok  = write_en && !fifo_full;
    assign read_ok   = read_en && !fifo_empty;
    assign wptr_next = wptr_bin + PTR_ONE;
    assign rptr_next = rptr_bin + PTR_ONE;

    // Write side: pointers advance only on an accepted write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
        end else if (write_ok) begin
            wptr_bin  <= wptr_next;
            wptr_gray <= bin2gray(wptr_next);
        end
    end

    // Storage has no reset; stale contents are unreachable behind the pointers.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wptr_bin[PNTR_WIDTH-1:0]] <= data_in;
        end
    end

    // Read side: data_out only changes on an accepted read and otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            data_out  <= '0;
        end else if (read_ok) begin
            data_out  <= mem[rptr_bin[PNTR_WIDTH-1:0]];
            rptr_bin  <= rptr_next;
            rptr_gray <= bin2gray(rptr_next);
        end
    end

`ifdef ASYNC_FIFO_BYPASS_SYNC_EN
    assign wptr_gray_sync = wptr_gray;
    assign rptr_gray_sync = rptr_gray;
`else
    ptr_sync #(.WIDTH(PNTR_WIDTH + 1)) u_wptr_sync (
        .clk   (clk),
        .reset (reset),
        .d     (wptr_gray),
        .q     (wptr_gray_sync)
    );

    ptr_sync #(.WIDTH(PNTR_WIDTH + 1)) u_rptr_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rptr_gray),
        .q     (rptr_gray_sync)
    );
`endif

    // Full when the pointers match except for the top two Gray bits (one lap apart).
    assign fifo_empty = (rptr_gray == wptr_gray_sync);
    assign fifo_full  = (wptr_gray == {~rptr_gray_sync[PNTR_WIDTH:PNTR_WIDTH-1],
                                        rptr_gray_sync[PNTR_WIDTH-2:0]});

    assign write_pointer_bin_rdclk = gray2bin(wptr_gray_sync);
    assign read_pointer_bin_wrclk  = gray2bin(rptr_gray_sync);

    // Each side's view of the fill level can never exceed the capacity.
    assign wr_side_level = wptr_bin - read_pointer_bin_wrclk;
    assign rd_side_level = write_pointer_bin_rdclk - rptr_bin;

    assert property (@(posedge clk) disable iff (!reset) wr_side_level <= DEPTH_LEVEL);
    assert property (@(posedge clk) disable iff (!reset) rd_side_level <= DEPTH_LEVEL);

endmodule

// File: tb/tb_async_fifo_core.sv
// Self-checking bench for async_fifo_core: vector tables, corner sequences and a queue-based model.
module tb_async_fifo_core;
    import conversionFunctions::*;

    localparam int DEPTH = 512;
`ifdef ASYNC_FIFO_BYPASS_SYNC_EN
    localparam bit SYNC_LAT = 1'b0;
`else
    localparam bit SYNC_LAT = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic        read_en;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        fifo_full;
    logic        fifo_empty;

    always #5 clk = ~clk;

    async_fifo_core dut (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .read_en    (read_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference: a word queue plus accepted-word counts, each side seeing the other's count two edges late.
    logic [15:0] model_q [$];
    int          w_total, r_total, w_d1, w_d2, r_d1, r_d2;
    logic [15:0] exp_dout;

    typedef struct {
        logic [9:0] bin;
        logic [9:0] gray;
    } gray_vec_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] din;
        logic        exp_empty;
        logic        exp_full;
        logic [15:0] exp_dout;
    } lat_vec_t;

    gray_vec_t gvec [10];
    lat_vec_t  lvec [6];
    bit        aw, ar;
    int        got, wr_cnt, rd_cnt;
    bit        saw_top, saw_wrap, we_r, re_r;

    function automatic bit model_empty();
        return SYNC_LAT ? (r_total == w_d2) : (r_total == w_total);
    endfunction

    function automatic bit model_full();
        return SYNC_LAT ? ((w_total - r_d2) == DEPTH) : ((w_total - r_total) == DEPTH);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        w_total = 0; r_total = 0;
        w_d1 = 0; w_d2 = 0; r_d1 = 0; r_d2 = 0;
        exp_dout = 16'h0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b0; data_in = 16'h0;
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("reset fifo_empty", 32'(fifo_empty), 32'd1);
        checkOutput("reset fifo_full", 32'(fifo_full), 32'd0);
        checkOutput("reset data_out", 32'(data_out), 32'd0);
    endtask

    // One clock edge: drive at negedge, accept per the model's flags, update the model after the edge.
    task automatic applyStimulus(input logic we, input logic re, input logic [15:0] din,
                                 output bit acc_w, output bit acc_r);
        @(negedge clk);
        write_en = we; read_en = re; data_in = din;
        acc_w = we && !model_full();
        acc_r = re && !model_empty();
        @(posedge clk);
        #1;
        w_d2 = w_d1; w_d1 = w_total;
        r_d2 = r_d1; r_d1 = r_total;
        if (acc_r) exp_dout = model_q.pop_front();
        if (acc_w) model_q.push_back(din);
        w_total += int'(acc_w);
        r_total += int'(acc_r);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " data_out"}, 32'(data_out), 32'(exp_dout));
        checkOutput({tag, " fifo_empty"}, 32'(fifo_empty), 32'(model_empty()));
        checkOutput({tag, " fifo_full"}, 32'(fifo_full), 32'(model_full()));
    endtask

    initial begin
        reset = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = 16'h0;
        modelReset();

        gvec[0] = '{10'd0,   10'd0};
        gvec[1] = '{10'd10,  10'd15};
        gvec[2] = '{10'd51,  10'd42};
        gvec[3] = '{10'd511, 10'd256};
        gvec[4] = '{10'd1,   10'd1};
        gvec[5] = '{10'd45,  10'd59};
        gvec[6] = '{10'd100, 10'd86};
        gvec[7] = '{10'd101, 10'd87};
        gvec[8] = '{10'd250, 10'd135};
        gvec[9] = '{10'd41,  10'd61};

        lvec[0] = '{1'b1, 1'b0, 16'h1234, SYNC_LAT, 1'b0, 16'h0000};
        lvec[1] = '{1'b0, 1'b0, 16'h0000, SYNC_LAT, 1'b0, 16'h0000};
        lvec[2] = '{1'b0, 1'b0, 16'h0000, 1'b0,     1'b0, 16'h0000};
        lvec[3] = '{1'b0, 1'b1, 16'h0000, 1'b1,     1'b0, 16'h1234};
        lvec[4] = '{1'b0, 1'b1, 16'h0000, 1'b1,     1'b0, 16'h1234};
        lvec[5] = '{1'b1, 1'b0, 16'h5678, SYNC_LAT, 1'b0, 16'h1234};

        for (int i = 0; i < 10; i++) begin
            checkOutput("bin2gray", 32'(bin2gray(gvec[i].bin)), 32'(gvec[i].gray));
            checkOutput("gray2bin", 32'(gray2bin(gvec[i].gray)), 32'(gvec[i].bin));
        end

        applyReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0, aw, ar);
            checkOutput("empty-read data_out", 32'(data_out), 32'd0);
            checkOutput("empty-read fifo_empty", 32'(fifo_empty), 32'd1);
            checkOutput("empty-read rptr", 32'(dut.rptr_bin), 32'd0);
        end

        applyReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(lvec[i].we, lvec[i].re, lvec[i].din, aw, ar);
            checkOutput("latency fifo_empty", 32'(fifo_empty), 32'(lvec[i].exp_empty));
            checkOutput("latency fifo_full", 32'(fifo_full), 32'(lvec[i].exp_full));
            checkOutput("latency data_out", 32'(data_out), 32'(lvec[i].exp_dout));
        end

        applyReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i), aw, ar);
            checkModel("fill");
        end
        checkOutput("full after fill", 32'(fifo_full), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'hDEAD, aw, ar);
        checkOutput("overflow keeps full", 32'(fifo_full), 32'd1);
        checkModel("overflow");
        got = 0;
        for (int c = 0; c < 600 && got < DEPTH; c++) begin
            applyStimulus(1'b0, 1'b1, 16'h0, aw, ar);
            checkModel("drain");
            if (ar) begin
                checkOutput("drain order", 32'(data_out), 32'(got));
                got++;
            end
        end
        checkOutput("drain count", 32'(got), 32'(DEPTH));
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0, aw, ar);
        checkOutput("empty after drain", 32'(fifo_empty), 32'd1);

        applyReset();
        wr_cnt = 0; rd_cnt = 0; saw_top = 1'b0; saw_wrap = 1'b0;
        for (int c = 0; c < 8000 && rd_cnt < 1500; c++) begin
            we_r = (wr_cnt < 1500) && ((w_total - r_total) < 3);
            re_r = ($urandom_range(0, 3) != 0);
            applyStimulus(we_r, re_r, 16'(wr_cnt), aw, ar);
            if (aw) wr_cnt++;
            if (ar) begin
                checkOutput("wrap order", 32'(data_out), 32'(rd_cnt));
                rd_cnt++;
            end
            checkModel("wrap");
            if (dut.write_pointer_bin_rdclk == 10'd1023) saw_top = 1'b1;
            if (saw_top && dut.write_pointer_bin_rdclk == 10'd0) saw_wrap = 1'b1;
        end
        checkOutput("wrap count", 32'(rd_cnt), 32'd1500);
        checkOutput("wrap pointer rollover", 32'(saw_wrap), 32'd1);

        applyReset();
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 16'(i + 256), aw, ar);
        applyStimulus(1'b0, 1'b1, 16'h0, aw, ar);
        checkOutput("pre-reset data_out", 32'(data_out), 32'h100);
        write_en = 1'b0; read_en = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("mid-reset fifo_empty", 32'(fifo_empty), 32'd1);
        checkOutput("mid-reset fifo_full", 32'(fifo_full), 32'd0);
        checkOutput("mid-reset data_out", 32'(data_out), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'hBEEF, aw, ar);
        applyStimulus(1'b0, 1'b0, 16'h0, aw, ar);
        applyStimulus(1'b0, 1'b0, 16'h0, aw, ar);
        applyStimulus(1'b0, 1'b1, 16'h0, aw, ar);
        checkOutput("post-reset first word", 32'(data_out), 32'hBEEF);
        checkModel("post-reset");

        applyReset();
        for (int c = 0; c < 3000; c++) begin
            we_r = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 40));
            re_r = ($urandom_range(0, 99) < ((c < 1500) ? 40 : 75));
            applyStimulus(we_r, re_r, 16'($urandom), aw, ar);
            checkModel("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
